// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if
//   Bundles the decoder-facing request signals and the unit's responses for
//   the HI/LO multiply(-accumulate) unit.
//   master : the execute-stage driver (In_Valid, Flush, ALUOp, MULOp, Func, A, B)
//   slave  : the HI/LO unit (Stall, Result, Result_Valid, HI, LO)
interface hilo_muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  In_Valid;
   logic                  Flush;
   logic                  ALUOp;
   logic                  MULOp;
   logic [5:0]            Func;
   logic [DATA_WIDTH-1:0] A;
   logic [DATA_WIDTH-1:0] B;
   logic                  Stall;
   logic [DATA_WIDTH-1:0] Result;
   logic                  Result_Valid;
   logic [DATA_WIDTH-1:0] HI;
   logic [DATA_WIDTH-1:0] LO;

   modport master (
      output In_Valid, Flush, ALUOp, MULOp, Func, A, B,
      input  Stall, Result, Result_Valid, HI, LO
   );

   modport slave (
      input  In_Valid, Flush, ALUOp, MULOp, Func, A, B,
      output Stall, Result, Result_Valid, HI, LO
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle HI/LO multiply(-accumulate) unit for the execute stage. Owns
//   the architectural HI/LO registers, serves MULT/MULTU/MADD/MADDU/MSUB/MSUBU/
//   MTHI/MTLO/MFHI/MFLO/MUL and stalls the pipeline on HI/LO hazards.
//   Multiplies run one bit per cycle (DATA_WIDTH cycles) on operand magnitudes.
// Ports
//   Clock  : system clock
//   nReset : asynchronous active-low reset
//   bus    : hilo_muldiv_unit_if.slave (request in, Stall/Result/HI/LO out)
// Configuration
//   MULDIV_DIV_EN : when defined, adds DIV (0x1A) / DIVU (0x1B) as a restoring
//                   divider sharing the BUSY iteration path.
module hilo_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input logic               Clock,
   input logic               nReset,
   hilo_muldiv_unit_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;
   typedef enum logic [2:0] {OP_MULT, OP_MADD, OP_MSUB, OP_MUL, OP_DIV} op_e;

   state_e         state_q, state_d;
   op_e            op_q, op_d;
   logic [CW-1:0]  count_q, count_d;
   logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [2*W-1:0] p_q, p_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic           neg_q, neg_d;
`ifdef MULDIV_DIV_EN
   logic           neg_rem_q, neg_rem_d;
   logic [W-1:0]   a_q, a_d;
   logic [W:0]     div_rem_sh;
   logic [W-1:0]   div_quo_sh, div_diff, div_lo, div_hi;
   logic [2*W-1:0] div_next;
`endif

   logic           dec_mfhi, dec_mflo, dec_mthi, dec_mtlo, dec_long, dec_signed;
   op_e            dec_op;
   logic [W-1:0]   mag_a, mag_b;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_next, step_next, prod;
   logic           stall, result_valid;
   logic [W-1:0]   result;

   // Instruction decode. dec_long marks the multi-cycle ops that occupy BUSY.
   always_comb begin
      dec_mfhi   = bus.ALUOp && (bus.Func == 6'h10);
      dec_mthi   = bus.ALUOp && (bus.Func == 6'h11);
      dec_mflo   = bus.ALUOp && (bus.Func == 6'h12);
      dec_mtlo   = bus.ALUOp && (bus.Func == 6'h13);
      dec_long   = 1'b0;
      dec_signed = 1'b0;
      dec_op     = OP_MULT;
      if (bus.ALUOp) begin
         case (bus.Func)
            6'h18: begin dec_long = 1'b1; dec_signed = 1'b1; dec_op = OP_MULT; end
            6'h19: begin dec_long = 1'b1; dec_op = OP_MULT; end
`ifdef MULDIV_DIV_EN
            6'h1A: begin dec_long = 1'b1; dec_signed = 1'b1; dec_op = OP_DIV; end
            6'h1B: begin dec_long = 1'b1; dec_op = OP_DIV; end
`endif
            default: ;
         endcase
      end
      if (bus.MULOp) begin
         case (bus.Func)
            6'h00: begin dec_long = 1'b1; dec_signed = 1'b1; dec_op = OP_MADD; end
            6'h01: begin dec_long = 1'b1; dec_op = OP_MADD; end
            6'h02: begin dec_long = 1'b1; dec_signed = 1'b1; dec_op = OP_MUL; end
            6'h04: begin dec_long = 1'b1; dec_signed = 1'b1; dec_op = OP_MSUB; end
            6'h05: begin dec_long = 1'b1; dec_op = OP_MSUB; end
            default: ;
         endcase
      end
   end

   // Operand magnitudes; the sign is reapplied once the iteration finishes.
   always_comb begin
      mag_a = (dec_signed && bus.A[W-1]) ? -bus.A : bus.A;
      mag_b = (dec_signed && bus.B[W-1]) ? -bus.B : bus.B;
   end

   // One shift-add step: p_q holds {partial sum, remaining multiplier bits}.
   always_comb begin
      mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, mcand_q} : '0);
      mul_next = {mul_sum, p_q[W-1:1]};
      prod     = neg_q ? -mul_next : mul_next;
   end

`ifdef MULDIV_DIV_EN
   // One restoring-divide step on {remainder, dividend}; the shifted remainder
   // needs one extra bit before the trial subtraction.
   always_comb begin
      div_rem_sh = p_q[2*W-1:W-1];
      div_quo_sh = {p_q[W-2:0], 1'b0};
      div_diff   = div_rem_sh[W-1:0] - mcand_q;
      if (div_rem_sh >= {1'b0, mcand_q}) begin
         div_next = {div_diff, div_quo_sh | W'(1)};
      end else begin
         div_next = {div_rem_sh[W-1:0], div_quo_sh};
      end
      if (mcand_q == '0) begin
         div_lo = '1;
         div_hi = a_q;
      end else begin
         div_lo = neg_q ? -div_next[W-1:0] : div_next[W-1:0];
         div_hi = neg_rem_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];
      end
      step_next = (op_q == OP_DIV) ? div_next : mul_next;
   end
`else
   assign step_next = mul_next;
`endif

   // Next-state and output logic. Flush wins over everything and drops an
   // in-flight op without touching HI/LO.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      count_d      = count_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      p_d          = p_q;
      mcand_d      = mcand_q;
      neg_d        = neg_q;
`ifdef MULDIV_DIV_EN
      neg_rem_d    = neg_rem_q;
      a_d          = a_q;
`endif
      stall        = 1'b0;
      result       = '0;
      result_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.In_Valid && !bus.Flush) begin
               if (dec_mthi) hi_d = bus.A;
               if (dec_mtlo) lo_d = bus.A;
               if (dec_mfhi) begin
                  result       = hi_q;
                  result_valid = 1'b1;
               end
               if (dec_mflo) begin
                  result       = lo_q;
                  result_valid = 1'b1;
               end
               if (dec_long) begin
                  state_d   = ST_BUSY;
                  count_d   = CW'(W - 1);
                  op_d      = dec_op;
                  p_d       = {{W{1'b0}}, mag_a};
                  mcand_d   = mag_b;
                  neg_d     = dec_signed && (bus.A[W-1] ^ bus.B[W-1]);
`ifdef MULDIV_DIV_EN
                  neg_rem_d = dec_signed && bus.A[W-1];
                  a_d       = bus.A;
`endif
                  stall     = (dec_op == OP_MUL);
               end
            end
         end
         ST_BUSY: begin
            if (bus.Flush) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else begin
               stall   = bus.In_Valid && (dec_mfhi || dec_mflo || dec_mthi || dec_mtlo || dec_long);
               p_d     = step_next;
               count_d = count_q - 1'b1;
               if (count_q == '0) begin
                  count_d = '0;
                  state_d = (op_q == OP_MUL) ? ST_DONE : ST_IDLE;
                  case (op_q)
                     OP_MULT: {hi_d, lo_d} = prod;
                     OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod;
                     OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod;
                     OP_MUL:  p_d = prod;
`ifdef MULDIV_DIV_EN
                     OP_DIV:  begin hi_d = div_hi; lo_d = div_lo; end
`endif
                     default: ;
                  endcase
               end
            end
         end
         ST_DONE: begin
            // The upstream MUL is still presented here; it is retired, not re-accepted.
            state_d = ST_IDLE;
            if (!bus.Flush) begin
               result       = p_q[W-1:0];
               result_valid = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULT;
         count_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         p_q       <= '0;
         mcand_q   <= '0;
         neg_q     <= 1'b0;
`ifdef MULDIV_DIV_EN
         neg_rem_q <= 1'b0;
         a_q       <= '0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         count_q   <= count_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         p_q       <= p_d;
         mcand_q   <= mcand_d;
         neg_q     <= neg_d;
`ifdef MULDIV_DIV_EN
         neg_rem_q <= neg_rem_d;
         a_q       <= a_d;
`endif
      end
   end

   assign bus.Stall        = stall;
   assign bus.Result       = result;
   assign bus.Result_Valid = result_valid;
   assign bus.HI           = hi_q;
   assign bus.LO           = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
//   Self-checking bench for hilo_muldiv_unit: a table of directed vectors,
//   hand-written stall/reset/flush sequences, and randomized ops checked
//   against a 64-bit arithmetic model of HI/LO.
module tb_hilo_muldiv_unit;
   localparam logic [5:0] F_MFHI = 6'h10;
   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MFLO = 6'h12;
   localparam logic [5:0] F_MTLO = 6'h13;

   typedef struct {
      string       name;
      logic [31:0] preHi;
      logic [31:0] preLo;
      logic        alu;
      logic        mul;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      logic [31:0] expRes;
      logic        expRv;
      int          expStall;
   } vec_t;

   logic        Clock;
   logic        nReset;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs[$];
   logic [63:0] modelHilo;

   hilo_muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

   hilo_muldiv_unit #(.DATA_WIDTH(32)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   // Free-running clock, 10 ns period.
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Called at a negedge; presents one op, waits (bounded) until Stall drops,
   // captures Result, lets the op fire on the next edge and returns at a negedge.
   task automatic applyStimulus(input logic alu, input logic mul, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic rv, output logic [31:0] res, output int stallCycles);
      bus.In_Valid = 1'b1;
      bus.ALUOp    = alu;
      bus.MULOp    = mul;
      bus.Func     = fn;
      bus.A        = a;
      bus.B        = b;
      stallCycles  = 0;
      #1;
      while (bus.Stall === 1'b1 && stallCycles < 100) begin
         @(negedge Clock);
         #1;
         stallCycles++;
      end
      if (stallCycles >= 100) begin
         checks++;
         errors++;
         $display("[TB] FAIL stall timeout: got %0d stalled cycles, expected fewer than 100", stallCycles);
      end
      rv  = bus.Result_Valid;
      res = bus.Result;
      @(negedge Clock);
      bus.In_Valid = 1'b0;
      bus.ALUOp    = 1'b0;
      bus.MULOp    = 1'b0;
      bus.Func     = 6'h00;
   endtask

   task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
      logic rv;
      logic [31:0] res;
      int sc;
      applyStimulus(1'b1, 1'b0, F_MTHI, h, 32'h0, rv, res, sc);
      applyStimulus(1'b1, 1'b0, F_MTLO, l, 32'h0, rv, res, sc);
   endtask

   task automatic readHiLo(output logic [31:0] h, output logic [31:0] l);
      logic rv;
      int sc;
      applyStimulus(1'b1, 1'b0, F_MFHI, 32'h0, 32'h0, rv, h, sc);
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'h0, 32'h0, rv, l, sc);
   endtask

   task automatic addVec(input string n, input logic [31:0] ph, input logic [31:0] pl,
                         input logic alu, input logic mul, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic [31:0] er, input logic erv, input int es);
      vec_t v;
      v.name = n; v.preHi = ph; v.preLo = pl; v.alu = alu; v.mul = mul; v.fn = fn;
      v.a = a; v.b = b; v.expHi = eh; v.expLo = el; v.expRes = er; v.expRv = erv;
      v.expStall = es;
      vecs.push_back(v);
   endtask

   // Random op kinds: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 MUL, 7 DIV, 8 DIVU.
   task automatic kindCode(input int kind, output logic alu, output logic mul, output logic [5:0] fn);
      alu = 1'b0;
      mul = 1'b0;
      fn  = 6'h00;
      case (kind)
         0: begin alu = 1'b1; fn = 6'h18; end
         1: begin alu = 1'b1; fn = 6'h19; end
         2: begin mul = 1'b1; fn = 6'h00; end
         3: begin mul = 1'b1; fn = 6'h01; end
         4: begin mul = 1'b1; fn = 6'h04; end
         5: begin mul = 1'b1; fn = 6'h05; end
         6: begin mul = 1'b1; fn = 6'h02; end
         7: begin alu = 1'b1; fn = 6'h1A; end
         default: begin alu = 1'b1; fn = 6'h1B; end
      endcase
   endtask

   // Reference model: plain 64-bit arithmetic on {HI,LO}.
   task automatic modelOp(input int kind, input logic [31:0] a, input logic [31:0] b, output logic [31:0] res);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub, p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      res = 32'h0;
      case (kind)
         0: modelHilo = sa * sb;
         1: modelHilo = ua * ub;
         2: modelHilo = modelHilo + (sa * sb);
         3: modelHilo = modelHilo + (ua * ub);
         4: modelHilo = modelHilo - (sa * sb);
         5: modelHilo = modelHilo - (ua * ub);
         6: begin p = sa * sb; res = p[31:0]; end
         7: begin
            if (b == 32'h0) modelHilo = {a, 32'hFFFFFFFF};
            else begin q = sa / sb; r = sa % sb; modelHilo = {r[31:0], q[31:0]}; end
         end
         default: begin
            if (b == 32'h0) modelHilo = {a, 32'hFFFFFFFF};
            else begin p = ua / ub; modelHilo = {ua[31:0] % ub[31:0], p[31:0]}; end
         end
      endcase
   endtask

   initial begin
      logic        rv;
      logic [31:0] res, h, l, a, b, expRes;
      logic        alu, mul;
      logic [5:0]  fn;
      int          sc, kind, nKinds;

      // Directed vectors: {name, preHI, preLO, ALUOp, MULOp, Func, A, B, HI, LO, Result, Result_Valid, stall cycles}
      addVec("mult neg",    32'h0,  32'h0,  1, 0, 6'h18, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0,        0, 0);
      addVec("multu max",   32'h0,  32'h0,  1, 0, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h0,        0, 0);
      addVec("maddu",       32'h1,  32'h2,  0, 1, 6'h01, 32'h3,        32'h4,        32'h1,        32'hE,        32'h0,        0, 0);
      addVec("msub",        32'h1,  32'hE,  0, 1, 6'h04, 32'h1,        32'hF,        32'h0,        32'hFFFFFFFF, 32'h0,        0, 0);
      addVec("msubu",       32'h0,  32'h0,  0, 1, 6'h05, 32'h2,        32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 32'h0,        0, 0);
      addVec("madd signed", 32'h0,  32'hA,  0, 1, 6'h00, 32'hFFFFFFFE, 32'h3,        32'h0,        32'h4,        32'h0,        0, 0);
      addVec("mult minint", 32'h0,  32'h0,  1, 0, 6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        32'h0,        0, 0);
      addVec("mul",         32'h5,  32'h5,  0, 1, 6'h02, 32'h6,        32'h7,        32'h5,        32'h5,        32'd42,       1, 33);
      addVec("mul neg",     32'hAA, 32'hBB, 0, 1, 6'h02, 32'hFFFFFFFD, 32'h5,        32'hAA,       32'hBB,       32'hFFFFFFF1, 1, 33);
      addVec("noop alu",    32'h11, 32'h22, 1, 0, 6'h20, 32'h9,        32'h9,        32'h11,       32'h22,       32'h0,        0, 0);
      addVec("noop none",   32'h11, 32'h22, 0, 0, 6'h18, 32'h9,        32'h9,        32'h11,       32'h22,       32'h0,        0, 0);
`ifdef MULDIV_DIV_EN
      addVec("div",         32'h0,  32'h0,  1, 0, 6'h1A, 32'd100,      32'd7,        32'd2,        32'd14,       32'h0,        0, 0);
      addVec("div neg",     32'h0,  32'h0,  1, 0, 6'h1A, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0,        0, 0);
      addVec("divu zero",   32'h0,  32'h0,  1, 0, 6'h1B, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 32'h0,        0, 0);
      nKinds = 9;
`else
      addVec("div noop",    32'h11, 32'h22, 1, 0, 6'h1A, 32'd100,      32'd7,        32'h11,       32'h22,       32'h0,        0, 0);
      addVec("divu noop",   32'h11, 32'h22, 1, 0, 6'h1B, 32'd5,        32'd0,        32'h11,       32'h22,       32'h0,        0, 0);
      nKinds = 7;
`endif

      bus.In_Valid = 1'b0;
      bus.Flush    = 1'b0;
      bus.ALUOp    = 1'b0;
      bus.MULOp    = 1'b0;
      bus.Func     = 6'h00;
      bus.A        = 32'h0;
      bus.B        = 32'h0;
      nReset       = 1'b0;

      // Reset state.
      repeat (2) @(negedge Clock);
      #1;
      checkOutput("reset Stall", bus.Stall, 1'b0);
      checkOutput("reset Result_Valid", bus.Result_Valid, 1'b0);
      checkOutput("reset Result", bus.Result, 32'h0);
      checkOutput("reset HI", bus.HI, 32'h0);
      checkOutput("reset LO", bus.LO, 32'h0);
      @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);

      // Table-driven vectors.
      foreach (vecs[i]) begin
         writeHiLo(vecs[i].preHi, vecs[i].preLo);
         applyStimulus(vecs[i].alu, vecs[i].mul, vecs[i].fn, vecs[i].a, vecs[i].b, rv, res, sc);
         checkOutput({vecs[i].name, " stall cycles"}, sc, vecs[i].expStall);
         checkOutput({vecs[i].name, " Result_Valid"}, rv, vecs[i].expRv);
         if (vecs[i].expRv) checkOutput({vecs[i].name, " Result"}, res, vecs[i].expRes);
         readHiLo(h, l);
         checkOutput({vecs[i].name, " HI"}, h, vecs[i].expHi);
         checkOutput({vecs[i].name, " LO"}, l, vecs[i].expLo);
         checkOutput({vecs[i].name, " HI port"}, bus.HI, vecs[i].expHi);
         checkOutput({vecs[i].name, " LO port"}, bus.LO, vecs[i].expLo);
      end

      // MULT at cycle 0, MFLO at cycle 1: 32 stalled cycles, then LO returned.
      writeHiLo(32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 6'h18, 32'd5, 32'd9, rv, res, sc);
      checkOutput("mult fire-and-forget stall", sc, 0);
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'h0, 32'h0, rv, res, sc);
      checkOutput("mflo hazard stall cycles", sc, 32);
      checkOutput("mflo hazard Result_Valid", rv, 1'b1);
      checkOutput("mflo hazard Result", res, 32'd45);

      // Reset in the middle of a multiply.
      writeHiLo(32'h1234, 32'h5678);
      applyStimulus(1'b1, 1'b0, 6'h18, 32'd100, 32'd200, rv, res, sc);
      repeat (9) @(negedge Clock);
      bus.In_Valid = 1'b1;
      bus.ALUOp    = 1'b1;
      bus.Func     = F_MFHI;
      nReset       = 1'b0;
      #1;
      checkOutput("reset mid-op Stall", bus.Stall, 1'b0);
      checkOutput("reset mid-op HI", bus.HI, 32'h0);
      checkOutput("reset mid-op LO", bus.LO, 32'h0);
      @(negedge Clock);
      nReset       = 1'b1;
      bus.In_Valid = 1'b0;
      bus.ALUOp    = 1'b0;
      repeat (40) @(negedge Clock);
      checkOutput("reset mid-op HI later", bus.HI, 32'h0);
      checkOutput("reset mid-op LO later", bus.LO, 32'h0);

      // Flush in the middle of a multiply keeps the prior HI/LO.
      writeHiLo(32'hAAAA, 32'hBBBB);
      applyStimulus(1'b1, 1'b0, 6'h18, 32'd3, 32'd3, rv, res, sc);
      repeat (9) @(negedge Clock);
      bus.In_Valid = 1'b1;
      bus.ALUOp    = 1'b1;
      bus.Func     = F_MFLO;
      bus.Flush    = 1'b1;
      #1;
      checkOutput("flush Stall", bus.Stall, 1'b0);
      @(negedge Clock);
      bus.Flush    = 1'b0;
      bus.In_Valid = 1'b0;
      bus.ALUOp    = 1'b0;
      applyStimulus(1'b1, 1'b0, F_MFLO, 32'h0, 32'h0, rv, res, sc);
      checkOutput("flush then mflo stall", sc, 0);
      checkOutput("flush then mflo Result", res, 32'hBBBB);
      repeat (40) @(negedge Clock);
      readHiLo(h, l);
      checkOutput("flush HI kept", h, 32'hAAAA);
      checkOutput("flush LO kept", l, 32'hBBBB);

      // Randomized ops against the arithmetic model.
      writeHiLo(32'h0, 32'h0);
      modelHilo = 64'h0;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            h = $urandom;
            l = $urandom;
            writeHiLo(h, l);
            modelHilo = {h, l};
         end
         kind = $urandom_range(0, nKinds - 1);
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
         b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3))  : 32'($urandom);
         kindCode(kind, alu, mul, fn);
         modelOp(kind, a, b, expRes);
         applyStimulus(alu, mul, fn, a, b, rv, res, sc);
         checkOutput($sformatf("rand %0d kind %0d stall", i, kind), sc, (kind == 6) ? 33 : 0);
         if (kind == 6) checkOutput($sformatf("rand %0d mul Result", i), res, expRes);
         readHiLo(h, l);
         checkOutput($sformatf("rand %0d kind %0d HI", i, kind), h, modelHilo[63:32]);
         checkOutput($sformatf("rand %0d kind %0d LO", i, kind), l, modelHilo[31:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
